// File: rtl/axi_lite_cfg_master_if.sv
// AXI_LITE: AXI-Lite bus bundle shared by initiator and target.
//
// Handshake rule for every channel (aw, w, b, ar, r): a beat transfers on a
// rising clk edge where <ch>_valid && <ch>_ready are both 1. Once valid is
// raised, the payload stays constant and valid stays high until that edge;
// valid never waits on ready.
//
// Signals per channel:
//   aw: aw_valid, aw_ready, aw_addr, aw_prot
//   w : w_valid,  w_ready,  w_data,  w_strb
//   b : b_valid,  b_ready,  b_resp
//   ar: ar_valid, ar_ready, ar_addr, ar_prot
//   r : r_valid,  r_ready,  r_data,  r_resp
// Modports: Master (initiator side), Slave (target side).
interface AXI_LITE #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      aw_valid;
    logic                      aw_ready;
    logic [ADDR_WIDTH-1:0]     aw_addr;
    logic [2:0]                aw_prot;

    logic                      w_valid;
    logic                      w_ready;
    logic [DATA_WIDTH-1:0]     w_data;
    logic [DATA_WIDTH/8-1:0]   w_strb;

    logic                      b_valid;
    logic                      b_ready;
    logic [1:0]                b_resp;

    logic                      ar_valid;
    logic                      ar_ready;
    logic [ADDR_WIDTH-1:0]     ar_addr;
    logic [2:0]                ar_prot;

    logic                      r_valid;
    logic                      r_ready;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [1:0]                r_resp;

    modport Master (
        output aw_valid, aw_addr, aw_prot, input aw_ready,
        output w_valid, w_data, w_strb, input w_ready,
        input b_valid, b_resp, output b_ready,
        output ar_valid, ar_addr, ar_prot, input ar_ready,
        input r_valid, r_data, r_resp, output r_ready
    );

    modport Slave (
        input aw_valid, aw_addr, aw_prot, output aw_ready,
        input w_valid, w_data, w_strb, output w_ready,
        output b_valid, b_resp, input b_ready,
        input ar_valid, ar_addr, ar_prot, output ar_ready,
        output r_valid, r_data, r_resp, input r_ready
    );
endinterface

// File: rtl/axi_lite_cfg_master.sv
// axi_lite_cfg_master: single-outstanding AXI-Lite initiator. Converts a
// command/response handshake into one AXI-Lite write or read at a time and
// returns the write response or read data on a registered response channel.
//
// Optional feature macro: AXI_LITE_CFG_MST_TIMEOUT_EN
//   Adds a per-transaction timeout (TIMEOUT_CYC cycles), the DRAIN state that
//   absorbs late beats, and a live rsp_timeout flag. Without it the block
//   waits indefinitely and rsp_timeout is tied to 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_we, cmd_addr, cmd_wdata,
//                       cmd_wstrb are the command payload
//   rsp_valid/ready     response handshake; rsp_rdata, rsp_resp,
//                       rsp_timeout are the response payload
//   dbg_state           current FSM state encoding (debug/observability)
//   mst                 AXI_LITE.Master initiator port
module axi_lite_cfg_master #(
    parameter int         AXI_ADDR_WIDTH = 32,
    parameter int         AXI_DATA_WIDTH = 32,
    parameter logic [2:0] AXI_PROT       = 3'b000,
    parameter int         TIMEOUT_CYC    = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_we,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic                        rsp_timeout,
    output logic [2:0]                  dbg_state,
    AXI_LITE.Master                     mst
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_WR_B  = 3'd2,
        S_RD_AR = 3'd3,
        S_RD_R  = 3'd4,
`ifdef AXI_LITE_CFG_MST_TIMEOUT_EN
        S_RSP   = 3'd5,
        S_DRAIN = 3'd6
`else
        S_RSP   = 3'd5
`endif
    } state_t;

    state_t                      state;
    logic                        aw_done;
    logic                        w_done;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_now, w_now;

    assign aw_hs  = mst.aw_valid && mst.aw_ready;
    assign w_hs   = mst.w_valid  && mst.w_ready;
    assign b_hs   = mst.b_valid  && mst.b_ready;
    assign ar_hs  = mst.ar_valid && mst.ar_ready;
    assign r_hs   = mst.r_valid  && mst.r_ready;
    // Address/data phase status including a handshake happening this cycle.
    assign aw_now = aw_done || aw_hs;
    assign w_now  = w_done  || w_hs;

    // Payload comes straight from registers latched at command acceptance,
    // so it is constant for the whole transaction.
    assign mst.aw_addr = addr_q;
    assign mst.ar_addr = addr_q;
    assign mst.aw_prot = AXI_PROT;
    assign mst.ar_prot = AXI_PROT;
    assign mst.w_data  = wdata_q;
    assign mst.w_strb  = wstrb_q;
    assign dbg_state   = state;

`ifdef AXI_LITE_CFG_MST_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TMO_W-1:0] tmo_cnt;
    logic             we_q;
    logic             beat_done;
    logic             active;
    logic             tmo_hit;

    assign active  = (state == S_WR) || (state == S_WR_B) ||
                     (state == S_RD_AR) || (state == S_RD_R);
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cmd_ready    <= 1'b0;
            mst.aw_valid <= 1'b0;
            mst.w_valid  <= 1'b0;
            mst.b_ready  <= 1'b0;
            mst.ar_valid <= 1'b0;
            mst.r_ready  <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_resp     <= 2'b00;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
`ifdef AXI_LITE_CFG_MST_TIMEOUT_EN
            tmo_cnt      <= '0;
            we_q         <= 1'b0;
            beat_done    <= 1'b0;
            rsp_timeout  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // cmd_ready rises one cycle after entering IDLE, which
                    // keeps commands and responses from overlapping.
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        wstrb_q   <= cmd_wstrb;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
`ifdef AXI_LITE_CFG_MST_TIMEOUT_EN
                        tmo_cnt     <= '0;
                        we_q        <= cmd_we;
                        beat_done   <= 1'b0;
                        rsp_timeout <= 1'b0;
`endif
                        if (cmd_we) begin
                            mst.aw_valid <= 1'b1;
                            mst.w_valid  <= 1'b1;
                            state        <= S_WR;
                        end else begin
                            mst.ar_valid <= 1'b1;
                            state        <= S_RD_AR;
                        end
                    end
                end
                S_WR: begin
                    if (aw_hs) mst.aw_valid <= 1'b0;
                    if (w_hs)  mst.w_valid  <= 1'b0;
                    aw_done <= aw_now;
                    w_done  <= w_now;
                    if (aw_now && w_now) begin
                        mst.b_ready <= 1'b1;
                        state       <= S_WR_B;
                    end
                end
                S_WR_B: begin
                    if (b_hs) begin
                        mst.b_ready <= 1'b0;
                        rsp_resp    <= mst.b_resp;
                        rsp_rdata   <= '0;
                        rsp_valid   <= 1'b1;
                        state       <= S_RSP;
                    end
                end
                S_RD_AR: begin
                    if (ar_hs) begin
                        mst.ar_valid <= 1'b0;
                        mst.r_ready  <= 1'b1;
                        state        <= S_RD_R;
                    end
                end
                S_RD_R: begin
                    if (r_hs) begin
                        mst.r_ready <= 1'b0;
                        rsp_rdata   <= mst.r_data;
                        rsp_resp    <= mst.r_resp;
                        rsp_valid   <= 1'b1;
                        state       <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
`ifdef AXI_LITE_CFG_MST_TIMEOUT_EN
                        state     <= rsp_timeout ? S_DRAIN : S_IDLE;
`else
                        state     <= S_IDLE;
`endif
                    end
                end
`ifdef AXI_LITE_CFG_MST_TIMEOUT_EN
                S_DRAIN: begin
                    if (beat_done || b_hs || r_hs) state <= S_IDLE;
                end
`endif
                default: state <= S_IDLE;
            endcase

`ifdef AXI_LITE_CFG_MST_TIMEOUT_EN
            if (active) tmo_cnt <= tmo_cnt + 1'b1;

            // Timeout overrides the normal transition unless the transaction
            // completes on this very edge. Partial handshakes recorded by the
            // case above still stand.
            if (active && tmo_hit && !(b_hs || r_hs)) begin
                state       <= S_RSP;
                rsp_valid   <= 1'b1;
                rsp_resp    <= 2'b10;
                rsp_rdata   <= '0;
                rsp_timeout <= 1'b1;
            end

            // After a timeout the abandoned transaction is still owed to the
            // slave: finish pending address/data phases and swallow the
            // B or R beat before accepting a new command.
            if ((state == S_RSP && rsp_timeout) || state == S_DRAIN) begin
                if (aw_hs) begin
                    mst.aw_valid <= 1'b0;
                    aw_done      <= 1'b1;
                end
                if (w_hs) begin
                    mst.w_valid <= 1'b0;
                    w_done      <= 1'b1;
                end
                if (ar_hs) begin
                    mst.ar_valid <= 1'b0;
                    mst.r_ready  <= 1'b1;
                end
                if (b_hs || r_hs) begin
                    mst.b_ready <= 1'b0;
                    mst.r_ready <= 1'b0;
                    beat_done   <= 1'b1;
                end else if (we_q && aw_now && w_now && !beat_done) begin
                    mst.b_ready <= 1'b1;
                end
            end
`endif
        end
    end

endmodule
